// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cpu_pkg
//  Description : Shared constants for the 5-stage pipeline. It holds the opcode
//                values the decoder matches on, the ALU_op width and encodings,
//                the register address width and the immediate field width.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Register file geometry
    localparam int c_REG_AW  = 5;
    localparam int c_IMM_W   = 16;

    // Control -> ALU control interface
    localparam int c_ALUOP_W = 2;

    localparam logic [c_ALUOP_W-1:0] c_ALUOP_ADD   = 2'b00;  // lw/sw address add
    localparam logic [c_ALUOP_W-1:0] c_ALUOP_SUB   = 2'b01;  // beq compare
    localparam logic [c_ALUOP_W-1:0] c_ALUOP_RTYPE = 2'b10;  // decode funct field
    localparam logic [c_ALUOP_W-1:0] c_ALUOP_RSVD  = 2'b11;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
//  Module      : load_use_detect
//  Description : Combinational load-use hazard detector. It flags an ID
//                instruction that reads the destination of a load in EX. A
//                load to register 0 never flags a hazard.
//  Ports       : ex_valid/ex_mem_r/ex_wr_addr - load currently in EX
//                id_valid/id_rs_*/id_rt_*     - source operands of ID
//                hazard                       - ID must wait one cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module load_use_detect
    import cpu_pkg::*;
#(
    parameter int REG_AW = c_REG_AW
) (
    input  logic              ex_valid,
    input  logic              ex_mem_r,
    input  logic [REG_AW-1:0] ex_wr_addr,
    input  logic              id_valid,
    input  logic              id_rs_used,
    input  logic [REG_AW-1:0] id_rs_addr,
    input  logic              id_rt_used,
    input  logic [REG_AW-1:0] id_rt_addr,
    output logic              hazard
);

    logic w_ex_load;
    logic w_rs_match;
    logic w_rt_match;

    // $0 is hard-wired, so a load targeting it produces nothing to wait for
    assign w_ex_load  = ex_valid & ex_mem_r & (ex_wr_addr != '0);
    assign w_rs_match = id_rs_used & (id_rs_addr == ex_wr_addr);
    assign w_rt_match = id_rt_used & (id_rt_addr == ex_wr_addr);
    assign hazard     = w_ex_load & id_valid & (w_rs_match | w_rt_match);

endmodule : load_use_detect
`default_nettype wire

// File: rtl/id_ex_hazard_reg.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_hazard_reg
//  Description : ID/EX pipeline register. It latches the decoded controls, the
//                register operands, the sign-extended immediate and the
//                selected destination for EX. A load-use hazard stalls
//                IF/PC/IF_ID for one cycle and injects a bubble. A branch flush
//                kills the ID instruction. Saturating counters track stalls
//                and flushes.
//  Ports       : clk, rst_n (sync, active low)
//                id_*     - decoded instruction from ID/Control/RF
//                flush    - kill the ID instruction (taken branch)
//                stall_if - hold PC and IF_ID this cycle (combinational)
//                ex_*     - registered EX-stage fields
//                stall_cnt, flush_cnt - saturating event counters
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex_hazard_reg
    import cpu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = c_REG_AW,
    parameter int ALUOP_W = c_ALUOP_W,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic               id_reg_dst,
    input  logic               id_reg_w,
    input  logic               id_mem_to_reg,
    input  logic               id_mem_w,
    input  logic               id_mem_r,
    input  logic [ALUOP_W-1:0] id_alu_op,
    input  logic               id_alu_src,
    input  logic               id_rs_used,
    input  logic               id_rt_used,
    input  logic [DATA_W-1:0]  id_rs_data,
    input  logic [DATA_W-1:0]  id_rt_data,
    input  logic [REG_AW-1:0]  id_rs_addr,
    input  logic [REG_AW-1:0]  id_rt_addr,
    input  logic [REG_AW-1:0]  id_rd_addr,
    input  logic [15:0]        id_imm16,
    input  logic               flush,
    output logic               stall_if,
    output logic               ex_valid,
    output logic               ex_reg_w,
    output logic               ex_mem_to_reg,
    output logic               ex_mem_w,
    output logic               ex_mem_r,
    output logic               ex_alu_src,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic [DATA_W-1:0]  ex_rs_data,
    output logic [DATA_W-1:0]  ex_rt_data,
    output logic [REG_AW-1:0]  ex_rs_addr,
    output logic [REG_AW-1:0]  ex_rt_addr,
    output logic [REG_AW-1:0]  ex_wr_addr,
    output logic [DATA_W-1:0]  ex_imm,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              w_hazard;
    logic              w_bubble;
    logic [REG_AW-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_imm_ext;

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_load_use_detect (
        .ex_valid   (ex_valid),
        .ex_mem_r   (ex_mem_r),
        .ex_wr_addr (ex_wr_addr),
        .id_valid   (id_valid),
        .id_rs_used (id_rs_used),
        .id_rs_addr (id_rs_addr),
        .id_rt_used (id_rt_used),
        .id_rt_addr (id_rt_addr),
        .hazard     (w_hazard)
    );

    // A flush already kills the ID instruction, so there is nothing to hold
    assign stall_if  = w_hazard & ~flush;
    assign w_bubble  = flush | w_hazard;
    assign w_wr_addr = id_reg_dst ? id_rd_addr : id_rt_addr;
    assign w_imm_ext = {{(DATA_W-c_IMM_W){id_imm16[c_IMM_W-1]}}, id_imm16};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid      <= 1'b0;
            ex_reg_w      <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_mem_w      <= 1'b0;
            ex_mem_r      <= 1'b0;
            ex_alu_src    <= 1'b0;
            ex_alu_op     <= '0;
            ex_rs_data    <= '0;
            ex_rt_data    <= '0;
            ex_rs_addr    <= '0;
            ex_rt_addr    <= '0;
            ex_wr_addr    <= '0;
            ex_imm        <= '0;
            stall_cnt     <= '0;
            flush_cnt     <= '0;
        end else begin
            if (w_bubble) begin
                // Bubble: no architectural side effects. Clearing ex_mem_r
                // also releases the hazard on the next cycle. Data fields
                // hold their old values because EX ignores them.
                ex_valid      <= 1'b0;
                ex_reg_w      <= 1'b0;
                ex_mem_to_reg <= 1'b0;
                ex_mem_w      <= 1'b0;
                ex_mem_r      <= 1'b0;
                ex_alu_src    <= 1'b0;
                ex_alu_op     <= '0;
            end else begin
                ex_valid      <= id_valid;
                ex_reg_w      <= id_valid & id_reg_w;
                ex_mem_to_reg <= id_valid & id_mem_to_reg;
                ex_mem_w      <= id_valid & id_mem_w;
                ex_mem_r      <= id_valid & id_mem_r;
                ex_alu_src    <= id_valid & id_alu_src;
                ex_alu_op     <= id_valid ? id_alu_op : '0;
                ex_rs_data    <= id_rs_data;
                ex_rt_data    <= id_rt_data;
                ex_rs_addr    <= id_rs_addr;
                ex_rt_addr    <= id_rt_addr;
                ex_wr_addr    <= w_wr_addr;
                ex_imm        <= w_imm_ext;
            end

            // A flush outranks the hazard, so it is the only event counted
            if (flush) begin
                if (id_valid && (flush_cnt != '1)) begin
                    flush_cnt <= flush_cnt + c_CNT_ONE;
                end
            end else if (w_hazard && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + c_CNT_ONE;
            end
        end
    end

endmodule : id_ex_hazard_reg
`default_nettype wire

// File: tb/tb_id_ex_hazard_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_hazard_reg
//  Description : Self-checking bench for id_ex_hazard_reg. Each driven cycle
//                pushes its predicted EX state onto a scoreboard queue. The
//                entry is popped and compared after the clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_hazard_reg;

    localparam int c_CNT_W = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_reg_dst, id_reg_w, id_mem_to_reg, id_mem_w, id_mem_r;
    logic [1:0]  id_alu_op;
    logic        id_alu_src, id_rs_used, id_rt_used;
    logic [31:0] id_rs_data, id_rt_data;
    logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
    logic [15:0] id_imm16;
    logic        flush;
    logic        stall_if;
    logic        ex_valid, ex_reg_w, ex_mem_to_reg, ex_mem_w, ex_mem_r, ex_alu_src;
    logic [1:0]  ex_alu_op;
    logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]  ex_rs_addr, ex_rt_addr, ex_wr_addr;
    logic [c_CNT_W-1:0] stall_cnt, flush_cnt;

    always #5 clk = ~clk;

    id_ex_hazard_reg #(
        .DATA_W (32), .REG_AW (5), .ALUOP_W (2), .CNT_W (c_CNT_W)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .id_valid (id_valid), .id_reg_dst (id_reg_dst), .id_reg_w (id_reg_w),
        .id_mem_to_reg (id_mem_to_reg), .id_mem_w (id_mem_w), .id_mem_r (id_mem_r),
        .id_alu_op (id_alu_op), .id_alu_src (id_alu_src),
        .id_rs_used (id_rs_used), .id_rt_used (id_rt_used),
        .id_rs_data (id_rs_data), .id_rt_data (id_rt_data),
        .id_rs_addr (id_rs_addr), .id_rt_addr (id_rt_addr), .id_rd_addr (id_rd_addr),
        .id_imm16 (id_imm16), .flush (flush), .stall_if (stall_if),
        .ex_valid (ex_valid), .ex_reg_w (ex_reg_w), .ex_mem_to_reg (ex_mem_to_reg),
        .ex_mem_w (ex_mem_w), .ex_mem_r (ex_mem_r), .ex_alu_src (ex_alu_src),
        .ex_alu_op (ex_alu_op), .ex_rs_data (ex_rs_data), .ex_rt_data (ex_rt_data),
        .ex_rs_addr (ex_rs_addr), .ex_rt_addr (ex_rt_addr), .ex_wr_addr (ex_wr_addr),
        .ex_imm (ex_imm), .stall_cnt (stall_cnt), .flush_cnt (flush_cnt)
    );

    typedef struct {
        logic        valid, reg_w, m2r, mw, mr, asrc;
        logic [1:0]  op;
        logic [31:0] rsd, rtd, imm;
        logic [4:0]  rsa, rta, wr;
        logic [c_CNT_W-1:0] sc, fc;
    } exp_t;

    exp_t m;          // reference model of the EX register contents
    exp_t sb_q[$];    // scoreboard
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic set_id(input logic v, rdst, rw, m2r, mw, mr, input logic [1:0] op,
                          input logic asrc, rsu, rtu, input logic [4:0] rs, rt, rd,
                          input logic [15:0] imm);
        id_valid = v;      id_reg_dst = rdst;  id_reg_w = rw;  id_mem_to_reg = m2r;
        id_mem_w = mw;     id_mem_r = mr;      id_alu_op = op; id_alu_src = asrc;
        id_rs_used = rsu;  id_rt_used = rtu;
        id_rs_addr = rs;   id_rt_addr = rt;    id_rd_addr = rd; id_imm16 = imm;
        id_rs_data = $urandom;
        id_rt_data = $urandom;
    endtask

    // One clock: check stall_if, predict next EX state, clock, compare.
    task automatic step();
        logic hz;
        exp_t e;
        #2;
        hz = m.valid & m.mr & (m.wr != 5'd0) & id_valid &
             ((id_rs_used & (id_rs_addr == m.wr)) | (id_rt_used & (id_rt_addr == m.wr)));
        if (rst_n) check("stall_if", {63'd0, stall_if}, {63'd0, hz & ~flush});

        if (!rst_n) begin
            m = '{default: '0};
        end else if (flush || hz) begin
            m.valid = 0; m.reg_w = 0; m.m2r = 0; m.mw = 0; m.mr = 0; m.asrc = 0; m.op = 0;
            if (flush) begin
                if (id_valid && m.fc != 4'hF) m.fc = m.fc + 4'd1;
            end else if (m.sc != 4'hF) begin
                m.sc = m.sc + 4'd1;
            end
        end else begin
            m.valid = id_valid;
            m.reg_w = id_valid & id_reg_w;
            m.m2r   = id_valid & id_mem_to_reg;
            m.mw    = id_valid & id_mem_w;
            m.mr    = id_valid & id_mem_r;
            m.asrc  = id_valid & id_alu_src;
            m.op    = id_valid ? id_alu_op : 2'd0;
            m.rsd   = id_rs_data;
            m.rtd   = id_rt_data;
            m.rsa   = id_rs_addr;
            m.rta   = id_rt_addr;
            m.wr    = id_reg_dst ? id_rd_addr : id_rt_addr;
            m.imm   = {{16{id_imm16[15]}}, id_imm16};
        end
        sb_q.push_back(m);

        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("ex_valid",  {63'd0, ex_valid},      {63'd0, e.valid});
        check("ex_reg_w",  {63'd0, ex_reg_w},      {63'd0, e.reg_w});
        check("ex_m2r",    {63'd0, ex_mem_to_reg}, {63'd0, e.m2r});
        check("ex_mem_w",  {63'd0, ex_mem_w},      {63'd0, e.mw});
        check("ex_mem_r",  {63'd0, ex_mem_r},      {63'd0, e.mr});
        check("ex_alu_src",{63'd0, ex_alu_src},    {63'd0, e.asrc});
        check("ex_alu_op", {62'd0, ex_alu_op},     {62'd0, e.op});
        check("stall_cnt", {60'd0, stall_cnt},     {60'd0, e.sc});
        check("flush_cnt", {60'd0, flush_cnt},     {60'd0, e.fc});
        // data and address fields are don't-care in a bubble
        if (e.valid || !rst_n) begin
            check("ex_rs_data", {32'd0, ex_rs_data}, {32'd0, e.rsd});
            check("ex_rt_data", {32'd0, ex_rt_data}, {32'd0, e.rtd});
            check("ex_rs_addr", {59'd0, ex_rs_addr}, {59'd0, e.rsa});
            check("ex_rt_addr", {59'd0, ex_rt_addr}, {59'd0, e.rta});
            check("ex_wr_addr", {59'd0, ex_wr_addr}, {59'd0, e.wr});
            check("ex_imm",     {32'd0, ex_imm},     {32'd0, e.imm});
        end
    endtask

    // Load word into EX: lw rt <- mem, reg_dst=0
    task automatic load_to(input logic [4:0] rt);
        set_id(1, 0, 1, 1, 0, 1, 2'b00, 1, 1, 0, 5'd1, rt, 5'd0, 16'h0004);
        step();
    endtask

    // R-type add reading rs/rt, writing rd
    task automatic add_op(input logic [4:0] rs, rt, rd);
        set_id(1, 1, 1, 0, 0, 0, 2'b10, 0, 1, 1, rs, rt, rd, 16'h0000);
    endtask

    initial begin
        m = '{default: '0};
        rst_n = 0; flush = 0;
        set_id(0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 5'd0, 5'd0, 5'd0, 16'h0);
        step();
        step();
        rst_n = 1;

        // Pass-through with negative immediate
        set_id(1, 1, 1, 0, 0, 0, 2'b10, 0, 1, 1, 5'd3, 5'd4, 5'd9, 16'h8000);
        step();
        check("t1_wr_addr", {59'd0, ex_wr_addr}, 64'd9);
        check("t1_imm",     {32'd0, ex_imm},     64'hFFFF8000);

        // Load-use on rs: stall, bubble, then add re-presented and latched
        load_to(5'd8);
        add_op(5'd8, 5'd2, 5'd10);
        step();
        check("t2_bubble", {63'd0, ex_valid}, 64'd0);
        check("t2_stalls", {60'd0, stall_cnt}, 64'd1);
        step();
        check("t2_latched", {59'd0, ex_wr_addr}, 64'd10);

        // Load-use on rt only; rt_used=0 must not stall
        load_to(5'd7);
        set_id(1, 0, 0, 0, 1, 0, 2'b00, 1, 1, 0, 5'd1, 5'd7, 5'd0, 16'h0010);
        step();
        load_to(5'd7);
        set_id(1, 0, 0, 0, 1, 0, 2'b00, 1, 1, 1, 5'd1, 5'd7, 5'd0, 16'h0010);
        step();
        step();

        // Load to $0 never stalls
        load_to(5'd0);
        add_op(5'd0, 5'd0, 5'd11);
        step();

        // Flush together with hazard
        load_to(5'd8);
        add_op(5'd8, 5'd2, 5'd12);
        flush = 1;
        step();
        check("t4_flushes", {60'd0, flush_cnt}, 64'd1);
        flush = 0;

        // Invalid ID instruction: controls gated
        set_id(0, 1, 1, 1, 1, 1, 2'b11, 1, 1, 1, 5'd5, 5'd6, 5'd7, 16'h1234);
        step();

        // Reset while a stall is pending
        load_to(5'd8);
        add_op(5'd8, 5'd2, 5'd13);
        rst_n = 0;
        step();
        rst_n = 1;
        step();

        // Saturation of the stall counter
        for (int i = 0; i < 20; i++) begin
            load_to(5'd9);
            add_op(5'd9, 5'd1, 5'd14);
            step();
        end
        check("t6_sat", {60'd0, stall_cnt}, 64'hF);

        // Random mix with small address space to provoke hazards
        for (int i = 0; i < 200; i++) begin
            set_id($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
                   2'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 1), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 16'($urandom));
            flush = ($urandom_range(0, 5) == 0);
            rst_n = ($urandom_range(0, 60) != 0);
            step();
        end
        rst_n = 1; flush = 0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_id_ex_hazard_reg
`default_nettype wire
